// File: rtl/fabric_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : fabric_config_loader
// Description : Accepts a word-wide configuration bitstream on a valid/ready
//               stream and serializes it, column by column, into per-column
//               hard or soft configuration chains. After the last column, a
//               one-cycle commit pulse is sent to every column, followed by a
//               one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module fabric_config_loader #(
    parameter int NUM_COLS     = 2,
    parameter int WORD_W       = 32,
    parameter int BITS_PER_COL = 64
) (
    input  logic                cclk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [NUM_COLS-1:0] shift_enable,
    output logic [NUM_COLS-1:0] shift_in_hard,
    output logic [NUM_COLS-1:0] shift_in_soft,
    output logic [NUM_COLS-1:0] set_hard,
    output logic [NUM_COLS-1:0] set_soft,
    output logic                busy,
    output logic                done
);

    // ------------------------------------------------------------------------
    // Widths and typed constants
    // ------------------------------------------------------------------------
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int BL_W  = $clog2(BITS_PER_COL + 1);
    localparam int CNT_W = $clog2(WORD_W + 1);

    localparam logic [BL_W-1:0]  BITS_FULL = BL_W'(BITS_PER_COL);
    localparam logic [BL_W-1:0]  BL_ONE    = BL_W'(1);
    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers with their next-state values
    // ------------------------------------------------------------------------
    state_t             state, state_nxt;
    logic               mode_lat, mode_lat_nxt;     // 0 = hard chain, 1 = soft chain
    logic [COL_W-1:0]   col, col_nxt;               // column currently being fed
    logic [BL_W-1:0]    bits_left, bits_left_nxt;   // bits still owed to this column
    logic [CNT_W-1:0]   word_cnt, word_cnt_nxt;     // bits still to shift from this word
    logic [WORD_W-1:0]  sreg, sreg_nxt;             // word being serialized, LSB first

    // Next values of the registered outputs
    logic                cfg_ready_nxt;
    logic [NUM_COLS-1:0] shift_enable_nxt;
    logic [NUM_COLS-1:0] shift_in_hard_nxt;
    logic [NUM_COLS-1:0] shift_in_soft_nxt;
    logic [NUM_COLS-1:0] set_hard_nxt;
    logic [NUM_COLS-1:0] set_soft_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    // State register
    always_ff @(posedge cclk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: latched mode, column/bit counters and shift register
    always_ff @(posedge cclk) begin
        if (rst) begin
            mode_lat  <= 1'b0;
            col       <= '0;
            bits_left <= '0;
            word_cnt  <= '0;
            sreg      <= '0;
        end else begin
            mode_lat  <= mode_lat_nxt;
            col       <= col_nxt;
            bits_left <= bits_left_nxt;
            word_cnt  <= word_cnt_nxt;
            sreg      <= sreg_nxt;
        end
    end

    // Next-state and datapath sequencing
    always_comb begin
        state_nxt     = state;
        mode_lat_nxt  = mode_lat;
        col_nxt       = col;
        bits_left_nxt = bits_left;
        word_cnt_nxt  = word_cnt;
        sreg_nxt      = sreg;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    mode_lat_nxt  = mode;
                    col_nxt       = '0;
                    bits_left_nxt = BITS_FULL;
                    state_nxt     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // cfg_ready is high throughout LOAD, so valid alone is a handshake.
                // Only as many bits as the column still needs are shifted; the
                // rest of the column's last word is dropped.
                if (cfg_valid && cfg_ready) begin
                    sreg_nxt     = cfg_data;
                    word_cnt_nxt = (32'(bits_left) >= WORD_W) ? WORD_BITS
                                                              : CNT_W'(bits_left);
                    state_nxt    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                sreg_nxt      = sreg >> 1;
                bits_left_nxt = bits_left - BL_ONE;
                word_cnt_nxt  = word_cnt - CNT_ONE;
                if (word_cnt == CNT_ONE) begin
                    if (bits_left != BL_ONE) begin
                        state_nxt = ST_LOAD;
                    end else if (col != LAST_COL) begin
                        // Column complete: the next column starts on a fresh word.
                        col_nxt       = col + COL_ONE;
                        bits_left_nxt = BITS_FULL;
                        state_nxt     = ST_LOAD;
                    end else begin
                        state_nxt = ST_COMMIT;
                    end
                end
            end

            ST_COMMIT: state_nxt = ST_DONE;

            ST_DONE:   state_nxt = ST_IDLE;

            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so every output leaves a flop and
    // reflects the state the machine is in during that cycle
    always_comb begin
        cfg_ready_nxt     = (state_nxt == ST_LOAD);
        busy_nxt          = (state_nxt != ST_IDLE);
        done_nxt          = (state_nxt == ST_DONE);
        set_hard_nxt      = '0;
        set_soft_nxt      = '0;
        shift_enable_nxt  = '0;
        shift_in_hard_nxt = '0;
        shift_in_soft_nxt = '0;

        if (state_nxt == ST_COMMIT) begin
            if (mode_lat_nxt) begin
                set_soft_nxt = '1;
            end else begin
                set_hard_nxt = '1;
            end
        end

        // Only the active column's enable and selected chain data are driven.
        for (int c = 0; c < NUM_COLS; c++) begin
            if ((state_nxt == ST_SHIFT) && (col_nxt == COL_W'(c))) begin
                shift_enable_nxt[c] = 1'b1;
                if (mode_lat_nxt) begin
                    shift_in_soft_nxt[c] = sreg_nxt[0];
                end else begin
                    shift_in_hard_nxt[c] = sreg_nxt[0];
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge cclk) begin
        if (rst) begin
            cfg_ready     <= 1'b0;
            shift_enable  <= '0;
            shift_in_hard <= '0;
            shift_in_soft <= '0;
            set_hard      <= '0;
            set_soft      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            cfg_ready     <= cfg_ready_nxt;
            shift_enable  <= shift_enable_nxt;
            shift_in_hard <= shift_in_hard_nxt;
            shift_in_soft <= shift_in_soft_nxt;
            set_hard      <= set_hard_nxt;
            set_soft      <= set_soft_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
        end
    end

endmodule
`default_nettype wire
